// File: rtl/i2c_write.sv
// Single-shot I2C master write engine: shifts a 27-bit frame (3 bytes, each followed by
// an ack slot) out on SCLK/SDIN and records the level seen in each ack slot.
module i2c_write #(
  parameter int QDIV = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [26:0] regdata,
  input  logic        GO,
  output logic        SCLK,
  output logic        SDIN,
  output logic        ACK,
  output logic        rstACK,
  output logic        ACK1,
  output logic        ACK2,
  output logic        ACK3,
  output logic        ldnACK1,
  output logic        ldnACK2,
  output logic        ldnACK3
);
  // state   | meaning
  // S_IDLE  | bus released, waiting for GO
  // S_START | start condition, 2 quarters
  // S_BIT   | one frame bit per 4 quarters, MSB first
  // S_STOP  | stop condition, 3 quarters, then idle

  localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLOAD = QW'(QDIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    phase, phase_n;
  logic [4:0]    bitn, bitn_n;
  logic [26:0]   frame;
  logic          sclk_n, sdin_n, accept, ack_load;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      phase   <= '0;
      bitn    <= '0;
      frame   <= '0;
      SCLK    <= 1'b1;
      SDIN    <= 1'b1;
      rstACK  <= 1'b0;
      ACK1    <= 1'b0;
      ACK2    <= 1'b0;
      ACK3    <= 1'b0;
      ldnACK1 <= 1'b1;
      ldnACK2 <= 1'b1;
      ldnACK3 <= 1'b1;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      phase   <= phase_n;
      bitn    <= bitn_n;
      SCLK    <= sclk_n;
      SDIN    <= sdin_n;
      rstACK  <= accept;
      ldnACK1 <= ~(ack_load && bitn_n == 5'd18);
      ldnACK2 <= ~(ack_load && bitn_n == 5'd9);
      ldnACK3 <= ~(ack_load && bitn_n == 5'd0);
      if (accept) begin
        frame <= regdata;
        ACK1  <= 1'b0;
        ACK2  <= 1'b0;
        ACK3  <= 1'b0;
      end else if (ack_load) begin
        // SDIN has been stable since q0 of this bit, so the port level is the slot level
        if (bitn_n == 5'd18) ACK1 <= SDIN;
        if (bitn_n == 5'd9)  ACK2 <= SDIN;
        if (bitn_n == 5'd0)  ACK3 <= SDIN;
      end
    end
  end

  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    phase_n = phase;
    bitn_n  = bitn;
    accept  = 1'b0;
    if (state == S_IDLE) begin
      if (GO) begin
        accept  = 1'b1;
        state_n = S_START;
        phase_n = 2'd0;
        qcnt_n  = QLOAD;
      end
    end else if (qcnt != '0) begin
      qcnt_n = qcnt - QW'(1);
    end else begin
      qcnt_n = QLOAD;
      case (state)
        S_START: begin
          if (phase == 2'd1) begin
            state_n = S_BIT;
            phase_n = 2'd0;
            bitn_n  = 5'd26;
          end else begin
            phase_n = phase + 2'd1;
          end
        end
        S_BIT: begin
          phase_n = phase + 2'd1;
          if (phase == 2'd3) begin
            if (bitn == 5'd0) state_n = S_STOP;
            else bitn_n = bitn - 5'd1;
          end
        end
        S_STOP: begin
          if (phase == 2'd2) begin
            state_n = S_IDLE;
            phase_n = 2'd0;
          end else begin
            phase_n = phase + 2'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are computed for the upcoming quarter and registered.
  always_comb begin
    sclk_n = 1'b1;
    sdin_n = 1'b1;
    case (state_n)
      S_START: begin
        sclk_n = (phase_n == 2'd0);
        sdin_n = 1'b0;
      end
      S_BIT: begin
        sclk_n = (phase_n == 2'd1) || (phase_n == 2'd2);
        sdin_n = (phase_n == 2'd0) ? frame[bitn_n] : SDIN;
      end
      S_STOP: begin
        sclk_n = (phase_n != 2'd0);
        sdin_n = (phase_n == 2'd2);
      end
      default: begin
        sclk_n = 1'b1;
        sdin_n = 1'b1;
      end
    endcase
  end

  assign ack_load = (state_n == S_BIT) && (phase_n == 2'd2) && (qcnt_n == '0);
  assign ACK      = ACK1 | ACK2 | ACK3;

endmodule

// File: tb/tb_i2c_write.sv
// Bench for i2c_write: QDIV=1 and QDIV=3 instances run the same frames; a bus monitor
// checks each against frames queued when GO was driven.
module tb_i2c_write;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [26:0] regdata = '0;
  logic        go = 1'b0;
  logic [1:0]  sclk, sdin, ack, rstack, ack1, ack2, ack3, ldn1, ldn2, ldn3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  i2c_write #(.QDIV(1)) dut1 (
    .CLK(clk), .reset(reset), .regdata(regdata), .GO(go),
    .SCLK(sclk[0]), .SDIN(sdin[0]), .ACK(ack[0]), .rstACK(rstack[0]),
    .ACK1(ack1[0]), .ACK2(ack2[0]), .ACK3(ack3[0]),
    .ldnACK1(ldn1[0]), .ldnACK2(ldn2[0]), .ldnACK3(ldn3[0])
  );

  i2c_write #(.QDIV(3)) dut3 (
    .CLK(clk), .reset(reset), .regdata(regdata), .GO(go),
    .SCLK(sclk[1]), .SDIN(sdin[1]), .ACK(ack[1]), .rstACK(rstack[1]),
    .ACK1(ack1[1]), .ACK2(ack2[1]), .ACK3(ack3[1]),
    .ldnACK1(ldn1[1]), .ldnACK2(ldn2[1]), .ldnACK3(ldn3[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: one queue of expected frames per instance
  logic [26:0] fq0[$];
  logic [26:0] fq1[$];

  logic [26:0] cur [2];
  logic [2:0]  ldn_seen [2];
  int          bitcnt [2];
  int          start_cyc [2];
  int          edge_cyc [2];
  int          done_cnt [2];
  logic [1:0]  active = 2'b00;
  logic [1:0]  p_sclk = 2'b11;
  logic [1:0]  p_sdin = 2'b11;
  logic        p_rst = 1'b1;
  int          idle_edges = 0;
  int          cyc = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      bitcnt[d] = 0; start_cyc[d] = 0; edge_cyc[d] = 0; done_cnt[d] = 0;
      ldn_seen[d] = '0; cur[d] = '0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int qd;
      qd = (d == 0) ? 1 : 3;
      if (reset || p_rst) begin
        active[d] = 1'b0;
      end else if (!active[d]) begin
        if (p_sclk[d] && sclk[d] && p_sdin[d] && !sdin[d]) begin
          active[d] = 1'b1;
          bitcnt[d] = 0;
          ldn_seen[d] = '0;
          start_cyc[d] = cyc;
          edge_cyc[d] = cyc;
          if (d == 0) begin
            check_val("d0_start_expected", 32'(fq0.size() > 0), 1);
            cur[0] = (fq0.size() > 0) ? fq0.pop_front() : '0;
          end else begin
            check_val("d1_start_expected", 32'(fq1.size() > 0), 1);
            cur[1] = (fq1.size() > 0) ? fq1.pop_front() : '0;
          end
        end else if (sclk[d] != p_sclk[d]) begin
          idle_edges++;
        end
      end else begin
        if (!p_sclk[d] && sclk[d]) begin
          if (bitcnt[d] == 0) check_val($sformatf("d%0d_first_rise", d), cyc - start_cyc[d], 3 * qd);
          else check_val($sformatf("d%0d_low_len", d), cyc - edge_cyc[d], 2 * qd);
          if (bitcnt[d] < 27)
            check_val($sformatf("d%0d_bit%0d", d, 26 - bitcnt[d]), 32'(sdin[d]), 32'(cur[d][26 - bitcnt[d]]));
          bitcnt[d]++;
          edge_cyc[d] = cyc;
        end else if (p_sclk[d] && !sclk[d]) begin
          if (bitcnt[d] > 0) check_val($sformatf("d%0d_high_len", d), cyc - edge_cyc[d], 2 * qd);
          edge_cyc[d] = cyc;
        end else if (p_sclk[d] && sclk[d] && p_sdin[d] != sdin[d]) begin
          if (sdin[d]) begin
            check_val($sformatf("d%0d_rises", d), bitcnt[d], 28);
            check_val($sformatf("d%0d_stop_time", d), cyc - start_cyc[d], 112 * qd);
            check_val($sformatf("d%0d_ldn_all", d), 32'(ldn_seen[d]), 7);
            active[d] = 1'b0;
            done_cnt[d]++;
          end else begin
            check_val($sformatf("d%0d_sdin_fell_sclk_high", d), 1, 0);
          end
        end
        if (!ldn1[d]) begin
          check_val($sformatf("d%0d_ldn1_pos", d), bitcnt[d], 9);
          check_val($sformatf("d%0d_ldn1_once", d), 32'(ldn_seen[d][0]), 0);
          check_val($sformatf("d%0d_ack1_val", d), 32'(ack1[d]), 32'(cur[d][18]));
          ldn_seen[d][0] = 1'b1;
        end
        if (!ldn2[d]) begin
          check_val($sformatf("d%0d_ldn2_pos", d), bitcnt[d], 18);
          check_val($sformatf("d%0d_ldn2_once", d), 32'(ldn_seen[d][1]), 0);
          check_val($sformatf("d%0d_ack2_val", d), 32'(ack2[d]), 32'(cur[d][9]));
          ldn_seen[d][1] = 1'b1;
        end
        if (!ldn3[d]) begin
          check_val($sformatf("d%0d_ldn3_pos", d), bitcnt[d], 27);
          check_val($sformatf("d%0d_ldn3_once", d), 32'(ldn_seen[d][2]), 0);
          check_val($sformatf("d%0d_ack3_val", d), 32'(ack3[d]), 32'(cur[d][0]));
          ldn_seen[d][2] = 1'b1;
        end
      end
      p_sclk[d] = sclk[d];
      p_sdin[d] = sdin[d];
    end
    p_rst = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("%s_d%0d_sclk", tag, d), 32'(sclk[d]), 1);
      check_val($sformatf("%s_d%0d_sdin", tag, d), 32'(sdin[d]), 1);
      check_val($sformatf("%s_d%0d_ldn", tag, d), 32'({ldn1[d], ldn2[d], ldn3[d]}), 7);
      check_val($sformatf("%s_d%0d_rstack", tag, d), 32'(rstack[d]), 0);
    end
  endtask

  task automatic check_acks(input string tag, input logic [26:0] f);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("%s_d%0d_acks", tag, d), 32'({ack1[d], ack2[d], ack3[d]}), 32'({f[18], f[9], f[0]}));
      check_val($sformatf("%s_d%0d_ack", tag, d), 32'(ack[d]), 32'(f[18] | f[9] | f[0]));
    end
  endtask

  task automatic send(input logic [26:0] f);
    regdata = f;
    go = 1'b1;
    fq0.push_back(f);
    fq1.push_back(f);
    tick(1);
    go = 1'b0;
    regdata = 27'($urandom);
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d_rstack_pulse", d), 32'(rstack[d]), 1);
      check_val($sformatf("d%0d_acks_cleared", d), 32'({ack1[d], ack2[d], ack3[d], ack[d]}), 0);
    end
    tick(1);
    for (int d = 0; d < 2; d++)
      check_val($sformatf("d%0d_rstack_one_clk", d), 32'(rstack[d]), 0);
  endtask

  task automatic wait_done(input int n);
    int budget;
    budget = 2000;
    while (!(done_cnt[0] >= n && done_cnt[1] >= n) && budget > 0) begin
      tick(1);
      budget--;
    end
    check_val("wait_done_timeout", 32'(budget > 0), 1);
    tick(5);
  endtask

  task automatic wait_bits(input int n);
    int budget;
    budget = 1000;
    while (bitcnt[0] < n && budget > 0) begin
      tick(1);
      budget--;
    end
    check_val("wait_bits_timeout", 32'(budget > 0), 1);
  endtask

  logic [26:0] fa, fc, fe;

  initial begin
    fa = 27'b101010101101010101101010101;
    fc = 27'h5A3C96F;
    fe = 27'($urandom);

    tick(2);
    reset = 1'b0;
    tick(20);
    check_idle("reset");
    for (int d = 0; d < 2; d++)
      check_val($sformatf("reset_d%0d_ack", d), 32'({ack[d], ack1[d], ack2[d], ack3[d]}), 0);
    check_val("reset_idle_edges", idle_edges, 0);

    send(fa);
    wait_done(1);
    check_acks("frame_a", fa);
    check_idle("after_a");

    send(27'h0);
    wait_done(2);
    check_acks("frame_zero", 27'h0);

    send(fc);
    wait_bits(7);
    go = 1'b1;
    tick(1);
    go = 1'b0;
    wait_done(3);
    check_acks("frame_c", fc);

    send(27'h7FFFFFF);
    wait_bits(17);
    reset = 1'b1;
    tick(1);
    check_idle("midreset");
    for (int d = 0; d < 2; d++)
      check_val($sformatf("midreset_d%0d_acks", d), 32'({ack1[d], ack2[d], ack3[d], ack[d]}), 0);
    reset = 1'b0;
    tick(100);
    check_val("midreset_idle_edges", idle_edges, 0);
    check_idle("after_midreset");
    check_val("midreset_done_cnt0", done_cnt[0], 3);

    send(fe);
    wait_done(4);
    check_acks("frame_e", fe);
    check_val("sb_empty0", fq0.size(), 0);
    check_val("sb_empty1", fq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
